// File: rtl/hazard_sb_unit_pkg.sv
// Shared constants for the hazard/scoreboard unit: bypass selects,
// write-back source encoding and the mul/div down-counter width.
package hazard_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2,
    WB_RSV  = 2'd3
  } wbsel_e;

  localparam logic [2:0] FWD_RF     = 3'b000;
  localparam logic [2:0] FWD_EX     = 3'b010;
  localparam logic [2:0] FWD_MEM    = 3'b100;
  localparam logic [2:0] FWD_WB_ALU = 3'b110;
  localparam logic [2:0] FWD_WB_MEM = 3'b111;

  // Link and reserved encodings resolve like ALU results.
  function automatic logic is_load(input logic [1:0] wbsel);
    return (wbsel == WB_MEM);
  endfunction

endpackage

// File: rtl/hazard_sb_unit_if.sv
// Pipeline-side bundle for hazard_sb_unit: ID operands, EX/MEM/WB
// write-back info, mul/div issue and the resulting stall/bypass controls.
interface hazard_sb_unit_if #(parameter int NRD = 2);

  logic [NRD*5-1:0] id_rs;
  logic [NRD-1:0]   id_rs_used;
  logic [4:0]       id_rd;
  logic             id_regwr;
  logic             id_md;
  logic             ex_regwr;
  logic [1:0]       ex_wbsel;
  logic [4:0]       ex_rd;
  logic             mem_regwr;
  logic [1:0]       mem_wbsel;
  logic [4:0]       mem_rd;
  logic             wb_regwr;
  logic [1:0]       wb_wbsel;
  logic [4:0]       wb_rd;
  logic             md_issue;
  logic [4:0]       md_rd;
  logic             flush;
  logic             stall;
  logic [NRD*3-1:0] fwd_sel;
  logic             md_busy;

  modport master (
    output id_rs, id_rs_used, id_rd, id_regwr, id_md,
    output ex_regwr, ex_wbsel, ex_rd, mem_regwr, mem_wbsel, mem_rd,
    output wb_regwr, wb_wbsel, wb_rd, md_issue, md_rd, flush,
    input  stall, fwd_sel, md_busy
  );

  modport slave (
    input  id_rs, id_rs_used, id_rd, id_regwr, id_md,
    input  ex_regwr, ex_wbsel, ex_rd, mem_regwr, mem_wbsel, mem_rd,
    input  wb_regwr, wb_wbsel, wb_rd, md_issue, md_rd, flush,
    output stall, fwd_sel, md_busy
  );

endinterface

// File: rtl/hazard_sb_unit_md_scoreboard.sv
// Single-entry mul/div scoreboard: tracks busy, the outstanding destination
// register and a down-counter of remaining result-latency cycles.
module md_scoreboard
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue,
  input  logic [4:0] issue_rd,
  output logic       busy,
  output logic [4:0] rd
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MD_LAT - 1);

  logic             busy_r, busy_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [4:0]       rd_r, rd_nxt_s;

  // Next-state: count down while busy, accept a new issue only when idle.
  always_comb begin
    busy_nxt_s = busy_r;
    cnt_nxt_s  = cnt_r;
    rd_nxt_s   = rd_r;
    if (busy_r) begin
      if (cnt_r == {CNT_W{1'b0}}) begin
        busy_nxt_s = 1'b0;
      end else begin
        cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else if (issue) begin
      busy_nxt_s = 1'b1;
      cnt_nxt_s  = LOAD_VAL;
      rd_nxt_s   = issue_rd;
    end else begin
      busy_nxt_s = 1'b0;
    end
  end

  // State register; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
      rd_r   <= 5'd0;
    end else begin
      busy_r <= busy_nxt_s;
      cnt_r  <= cnt_nxt_s;
      rd_r   <= rd_nxt_s;
    end
  end

  assign busy = busy_r;
  assign rd   = rd_r;

endmodule

// File: rtl/hazard_sb_unit.sv
// ID-stage hazard unit: per-port bypass select, load-use stall and mul/div
// scoreboard stall. Optional stall counter enabled by HAZARD_PERF_EN.
module hazard_sb_unit
  import hazard_pkg::*;
#(
  parameter int NRD    = 2,
  parameter int MD_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  hazard_sb_unit_if.slave    hif
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  logic             md_busy_s;
  logic [4:0]       md_rd_s;
  logic [NRD-1:0]   port_stall_s;
  logic [NRD-1:0]   md_hit_s;
  logic [NRD*3-1:0] fwd_raw_s;
  logic             md_waw_s;
  logic             stall_s;
  logic [NRD*3-1:0] fwd_s;

  md_scoreboard #(.MD_LAT(MD_LAT)) u_md_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .issue    (hif.md_issue),
    .issue_rd (hif.md_rd),
    .busy     (md_busy_s),
    .rd       (md_rd_s)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [4:0] rs_s;
    logic       act_s;
    logic [2:0] sel_s;
    logic       ld_stall_s;

    assign rs_s  = hif.id_rs[i*5 +: 5];
    assign act_s = hif.id_rs_used[i] && (rs_s != 5'd0);

    // Youngest matching producer wins; a load still in EX or MEM cannot bypass.
    always_comb begin
      sel_s      = FWD_RF;
      ld_stall_s = 1'b0;
      if (!act_s) begin
        sel_s = FWD_RF;
      end else if (hif.ex_regwr && (hif.ex_rd == rs_s)) begin
        if (is_load(hif.ex_wbsel)) begin
          ld_stall_s = 1'b1;
        end else begin
          sel_s = FWD_EX;
        end
      end else if (hif.mem_regwr && (hif.mem_rd == rs_s)) begin
        if (is_load(hif.mem_wbsel)) begin
          ld_stall_s = 1'b1;
        end else begin
          sel_s = FWD_MEM;
        end
      end else if (hif.wb_regwr && (hif.wb_rd == rs_s)) begin
        if (is_load(hif.wb_wbsel)) begin
          sel_s = FWD_WB_MEM;
        end else begin
          sel_s = FWD_WB_ALU;
        end
      end else begin
        sel_s = FWD_RF;
      end
    end

    assign port_stall_s[i]     = ld_stall_s;
    assign md_hit_s[i]         = act_s && md_busy_s && (rs_s == md_rd_s);
    assign fwd_raw_s[i*3 +: 3] = sel_s;
  end

  // x0 destinations never block a following writer.
  assign md_waw_s = md_busy_s && hif.id_regwr && (hif.id_rd == md_rd_s) && (md_rd_s != 5'd0);

  // Flush squashes the ID instruction, so it needs neither stall nor bypass.
  always_comb begin
    stall_s = 1'b0;
    fwd_s   = {(NRD*3){1'b0}};
    if (hif.flush) begin
      stall_s = 1'b0;
      fwd_s   = {(NRD*3){1'b0}};
    end else begin
      stall_s = (|port_stall_s) || (|md_hit_s) || md_waw_s || (md_busy_s && hif.id_md);
      fwd_s   = fwd_raw_s;
    end
  end

  assign hif.stall   = stall_s;
  assign hif.fwd_sel = fwd_s;
  assign hif.md_busy = md_busy_s;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_sb_unit.sv
// Scoreboard-style bench for hazard_sb_unit: expected stall/fwd_sel/md_busy
// are queued per cycle and compared on the falling edge.
module tb_hazard_sb_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_sb_unit_if #(.NRD(2)) hif ();

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
`endif

  hazard_sb_unit #(.NRD(2), .MD_LAT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .hif       (hif)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    string      tag;
    logic       stall;
    logic [5:0] fwd;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq({e.tag, ".stall"},   {31'd0, hif.stall},   {31'd0, e.stall});
      check_eq({e.tag, ".fwd_sel"}, {26'd0, hif.fwd_sel}, {26'd0, e.fwd});
      check_eq({e.tag, ".md_busy"}, {31'd0, hif.md_busy}, {31'd0, e.busy});
    end
  end

  task automatic clear_in();
    hif.id_rs = 10'd0;  hif.id_rs_used = 2'b00; hif.id_rd = 5'd0;
    hif.id_regwr = 1'b0; hif.id_md = 1'b0;
    hif.ex_regwr = 1'b0;  hif.ex_wbsel = 2'd0;  hif.ex_rd = 5'd0;
    hif.mem_regwr = 1'b0; hif.mem_wbsel = 2'd0; hif.mem_rd = 5'd0;
    hif.wb_regwr = 1'b0;  hif.wb_wbsel = 2'd0;  hif.wb_rd = 5'd0;
    hif.md_issue = 1'b0;  hif.md_rd = 5'd0;     hif.flush = 1'b0;
  endtask

  task automatic reads(input logic [4:0] rs1, input logic [4:0] rs0, input logic [1:0] used);
    hif.id_rs = {rs1, rs0};
    hif.id_rs_used = used;
  endtask

  // Queue this cycle's expectation, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic s, input logic [5:0] f, input logic b);
    exp_t e;
    e.tag = tag; e.stall = s; e.fwd = f; e.busy = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("reset", 1'b0, 6'b000000, 1'b0);

    // ALU result in EX bypassed to both ports
    hif.ex_regwr = 1'b1; hif.ex_rd = 5'd5; reads(5'd5, 5'd5, 2'b11);
    cyc("ex_alu", 1'b0, 6'b010010, 1'b0);

    // load-use: EX, MEM stall; WB bypasses memory data
    clear_in(); hif.ex_regwr = 1'b1; hif.ex_wbsel = 2'd1; hif.ex_rd = 5'd7; reads(5'd0, 5'd7, 2'b01);
    cyc("ld_ex", 1'b1, 6'b000000, 1'b0);
    clear_in(); hif.mem_regwr = 1'b1; hif.mem_wbsel = 2'd1; hif.mem_rd = 5'd7; reads(5'd0, 5'd7, 2'b01);
    cyc("ld_mem", 1'b1, 6'b000000, 1'b0);
    clear_in(); hif.wb_regwr = 1'b1; hif.wb_wbsel = 2'd1; hif.wb_rd = 5'd7; reads(5'd0, 5'd7, 2'b01);
    cyc("ld_wb", 1'b0, 6'b000111, 1'b0);

    // independent ports, MEM ALU over WB load
    clear_in();
    hif.ex_regwr = 1'b1; hif.ex_rd = 5'd3;
    hif.mem_regwr = 1'b1; hif.mem_rd = 5'd4;
    hif.wb_regwr = 1'b1; hif.wb_wbsel = 2'd1; hif.wb_rd = 5'd4;
    reads(5'd4, 5'd3, 2'b11);
    cyc("prio_mix", 1'b0, 6'b100010, 1'b0);

    // EX ALU shadows a MEM load of the same register
    clear_in();
    hif.ex_regwr = 1'b1; hif.ex_rd = 5'd3;
    hif.mem_regwr = 1'b1; hif.mem_wbsel = 2'd1; hif.mem_rd = 5'd3;
    reads(5'd0, 5'd3, 2'b01);
    cyc("prio_ex", 1'b0, 6'b000010, 1'b0);

    // link result in WB treated as ALU
    clear_in(); hif.wb_regwr = 1'b1; hif.wb_wbsel = 2'd2; hif.wb_rd = 5'd6; reads(5'd6, 5'd0, 2'b10);
    cyc("wb_link", 1'b0, 6'b110000, 1'b0);

    // unused ports ignore matches
    clear_in(); hif.ex_regwr = 1'b1; hif.ex_wbsel = 2'd1; hif.ex_rd = 5'd5; reads(5'd5, 5'd5, 2'b00);
    cyc("unused", 1'b0, 6'b000000, 1'b0);

    // x0 never forwards or stalls
    clear_in();
    hif.ex_regwr = 1'b1; hif.ex_wbsel = 2'd1;
    hif.mem_regwr = 1'b1; hif.wb_regwr = 1'b1; hif.wb_wbsel = 2'd1;
    reads(5'd0, 5'd0, 2'b11);
    cyc("x0", 1'b0, 6'b000000, 1'b0);

    // flush masks both stall and bypass
    clear_in(); hif.ex_regwr = 1'b1; hif.ex_wbsel = 2'd1; hif.ex_rd = 5'd7;
    hif.mem_regwr = 1'b1; hif.mem_rd = 5'd8; reads(5'd8, 5'd7, 2'b11); hif.flush = 1'b1;
    cyc("flush", 1'b0, 6'b000000, 1'b0);

    // mul/div x9, MD_LAT=4: four stall cycles
    clear_in(); hif.md_issue = 1'b1; hif.md_rd = 5'd9; reads(5'd0, 5'd9, 2'b01);
    cyc("md_issue", 1'b0, 6'b000000, 1'b0);
    hif.md_issue = 1'b0;
    for (int i = 0; i < 4; i++) cyc("md_busy", 1'b1, 6'b000000, 1'b1);
    cyc("md_release", 1'b0, 6'b000000, 1'b0);

    // WAW, id_md, ignored second issue, final-cycle stall
    clear_in(); hif.md_issue = 1'b1; hif.md_rd = 5'd10;
    cyc("md2_issue", 1'b0, 6'b000000, 1'b0);
    clear_in(); hif.id_regwr = 1'b1; hif.id_rd = 5'd10;
    cyc("md2_waw", 1'b1, 6'b000000, 1'b1);
    clear_in(); hif.id_md = 1'b1;
    cyc("md2_idmd", 1'b1, 6'b000000, 1'b1);
    clear_in(); hif.md_issue = 1'b1; hif.md_rd = 5'd11; reads(5'd0, 5'd11, 2'b01);
    cyc("md2_reissue", 1'b0, 6'b000000, 1'b1);
    clear_in(); reads(5'd0, 5'd10, 2'b01);
    cyc("md2_last", 1'b1, 6'b000000, 1'b1);
    cyc("md2_release", 1'b0, 6'b000000, 1'b0);

    // md_rd = x0 occupies the unit without stalling reads
    clear_in(); hif.md_issue = 1'b1; hif.md_rd = 5'd0; reads(5'd5, 5'd0, 2'b11);
    cyc("md0_issue", 1'b0, 6'b000000, 1'b0);
    hif.md_issue = 1'b0;
    for (int i = 0; i < 4; i++) cyc("md0_busy", 1'b0, 6'b000000, 1'b1);
    cyc("md0_release", 1'b0, 6'b000000, 1'b0);

    // reset two cycles into a mul/div
    clear_in(); hif.md_issue = 1'b1; hif.md_rd = 5'd12; reads(5'd0, 5'd12, 2'b01);
    cyc("mdr_issue", 1'b0, 6'b000000, 1'b0);
    hif.md_issue = 1'b0;
    cyc("mdr_busy", 1'b1, 6'b000000, 1'b1);
    rst = 1'b1;
    cyc("mdr_rst", 1'b1, 6'b000000, 1'b1);
    rst = 1'b0;
    cyc("mdr_after", 1'b0, 6'b000000, 1'b0);
    cyc("mdr_after2", 1'b0, 6'b000000, 1'b0);

    // flush leaves an in-flight mul/div running
    clear_in(); hif.md_issue = 1'b1; hif.md_rd = 5'd13; reads(5'd0, 5'd13, 2'b01);
    cyc("mdf_issue", 1'b0, 6'b000000, 1'b0);
    hif.md_issue = 1'b0; hif.flush = 1'b1;
    cyc("mdf_flush", 1'b0, 6'b000000, 1'b1);
    hif.flush = 1'b0;
    for (int i = 0; i < 3; i++) cyc("mdf_busy", 1'b1, 6'b000000, 1'b1);
    cyc("mdf_release", 1'b0, 6'b000000, 1'b0);

`ifdef HAZARD_PERF_EN
    clear_in(); rst = 1'b1;
    cyc("perf_rst", 1'b0, 6'b000000, 1'b0);
    rst = 1'b0;
    check_eq("perf_cnt_rst", stall_cnt, 32'd0);
    hif.ex_regwr = 1'b1; hif.ex_wbsel = 2'd1; hif.ex_rd = 5'd7; reads(5'd0, 5'd7, 2'b01);
    for (int i = 0; i < 3; i++) cyc("perf_stall", 1'b1, 6'b000000, 1'b0);
    hif.flush = 1'b1;
    check_eq("perf_cnt3", stall_cnt, 32'd3);
    cyc("perf_flush", 1'b0, 6'b000000, 1'b0);
    check_eq("perf_cnt_hold", stall_cnt, 32'd3);
`endif

    clear_in();
    repeat (2) @(posedge clk);
    check_eq("queue_drain", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_sb_unit.md
HAZARD_SB_UNIT -- requirements
Module: hazard_sb_unit

Interface
REQ-001 SHALL have parameter NRD, default 2, number of ID-stage register read ports.
REQ-002 SHALL have parameter MD_LAT, default 4, multi-cycle (mul/div) result latency in cycles, legal range 2..15.
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports id_rs, input, NRD*5, source register indices; id_rs_used, input, NRD, per-port read-enable.
REQ-006 SHALL have ports id_rd, input, 5; id_regwr, input, 1; id_md, input, 1 (ID instruction is a mul/div).
REQ-007 SHALL have ports ex_/mem_/wb_ regwr, input, 1; wbsel, input, 2 (0=ALU, 1=memory, 2=link, treated as ALU); rd, input, 5.
REQ-008 SHALL have ports md_issue, input, 1 (mul/div leaves EX this cycle); md_rd, input, 5; flush, input, 1.
REQ-009 SHALL have ports stall, output, 1; fwd_sel, output, NRD*3, per-port bypass select; md_busy, output, 1.

Function
REQ-010 fwd_sel encoding SHALL be: 000 regfile, 010 EX ALU, 100 MEM ALU, 110 WB ALU, 111 WB memory.
REQ-011 Each read port SHALL be resolved independently; ports with id_rs_used=0 or id_rs=0 SHALL yield 000 and no stall.
REQ-012 Priority SHALL be youngest first: EX match, then MEM match, then WB match, then regfile.
REQ-013 EX match with wbsel=1 (load) SHALL assert stall; MEM match with wbsel=1 SHALL assert stall; WB match with wbsel=1 SHALL select 111.
REQ-014 An ALU/link match SHALL select 010/100/110 for EX/MEM/WB with no stall.
REQ-015 md_issue with md_busy=0 SHALL, at the next edge, set busy, latch md_rd, and load the down-counter with MD_LAT-1.
REQ-016 While busy the counter SHALL decrement each cycle; the cycle it reads 0 busy SHALL clear at the following edge.
REQ-017 md_rd=0 SHALL still occupy the unit but SHALL never cause an operand stall.
REQ-018 stall SHALL assert while busy if any used port reads the latched md_rd, or id_regwr with id_rd equals it (WAW), or id_md=1.
REQ-019 In the final busy cycle (counter 0) the scoreboard stall SHALL still assert; release occurs the next cycle.
REQ-020 md_issue while busy SHALL be ignored with no state change.
REQ-021 flush SHALL force stall=0 and fwd_sel=0 that cycle; it SHALL NOT cancel an in-flight mul/div.
REQ-022 stall and fwd_sel SHALL be combinational from inputs and registered state (zero latency).

Reset
REQ-023 rst SHALL clear busy, counter and latched rd at the next edge; md_busy=0 and the scoreboard stall SHALL be deasserted the cycle after.
REQ-024 rst mid mul/div SHALL abandon the operation; no residual stall.

Configuration
REQ-025 With HAZARD_PERF_EN defined, a 32-bit output stall_cnt SHALL count cycles with stall=1, saturating at 0xFFFFFFFF, cleared by rst.
REQ-026 Without HAZARD_PERF_EN, the stall_cnt port and counter SHALL be absent.

Structure
REQ-027 Package hazard_pkg SHALL hold the fwd_sel constants, the wbsel encoding and the counter width constant.
REQ-028 The busy/counter/rd tracker SHALL be sub-module md_scoreboard; per-port bypass logic SHALL be a generate loop.

Verification
REQ-029 EX ALU write x5, ID reads rs1=x5, rs2=x5 -> fwd_sel=010/010, stall=0.
REQ-030 EX load x7, ID reads x7 -> stall=1; next cycle load in MEM -> stall=1; then WB -> fwd_sel=111, stall=0.
REQ-031 md_issue rd=x9, MD_LAT=4, ID reads x9 -> stall high exactly 4 cycles, released in cycle 5.
REQ-032 Reads of x0 while EX/MEM/WB all write x0 -> fwd_sel=000, stall=0.
REQ-033 rst asserted 2 cycles into a mul/div -> md_busy=0 and stall=0 from the next cycle; a second md_issue while busy is ignored.
REQ-034 With HAZARD_PERF_EN, 3 stall cycles followed by flush -> stall_cnt=3.
